tdc_measure_ctrl: RTL and testbench
===================================

# tdc_measure_ctrl

Measurement sequencer for one TDC channel. It arms the channel, detects the start and stop hits, runs the coarse cycle counter between them, and fires `go` into the start and stop edge-detector decoders. It then collects their fine codes and presents one result word per measurement on a valid/ready handshake. It sits between the hit synchronizers and the readout FIFO.

## Interface
- `COARSE_W`, 16: coarse counter width.
- `DEC_TO`, 7: cycles allowed from `go` to decoder `finished` before error (decoder nominal is 4).
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-low reset.
- `arm` in 1: one-cycle request to start a measurement. Ignored unless IDLE.
- `start_hit` in 1: synchronized start-hit pulse.
- `stop_hit` in 1: synchronized stop-hit pulse.
- `start_go`, `stop_go` out 1: one-cycle pulses to the start and stop decoders.
- `start_fin`, `stop_fin` in 1: decoder finished pulses.
- `start_fine`, `stop_fine` in `NUM_DECODE`: decoder outputs, sampled on the matching `*_fin`.
- `busy` out 1: high in every state except IDLE.
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer accepts the result.
- `res_coarse` out `COARSE_W`: coarse count.
- `res_start_fine`, `res_stop_fine` out `NUM_DECODE`: fine codes.
- `res_ovf` out 1: coarse counter overflowed.
- `res_err` out 1: decoder watchdog expired.

## Operation
- **States:** IDLE, ARMED, RUN, DECODE, OUT.
- **IDLE:**
  - `arm` → ARMED.
  - Hits are ignored.
- **ARMED:**
  - `start_hit` → start_go pulse next cycle; cnt<=1; → RUN.
  - `start_hit` and `stop_hit` in the same cycle → both go pulses; coarse latched 0; → DECODE.
  - `stop_hit` alone is ignored.
- **RUN:**
  - cnt increments by 1 each cycle.
  - `stop_hit` → latch cnt into coarse; stop_go pulse next cycle; → DECODE.
  - cnt equals all-ones with no stop → coarse = all-ones; ovf=1; stop fine = 0; → DECODE. No stop_go is issued; only start_fin is awaited.
  - A `start_hit` seen in RUN is ignored.
- **DECODE:**
  - Each `*_fin` captures its fine code and sets a per-side done flag.
  - start_fin may arrive while still in RUN; it is captured there.
  - Both required flags set → OUT.
  - The watchdog counts from the later go pulse. If it reaches `DEC_TO` → err=1, missing fine code = 0, → OUT.
- **OUT:**
  - `res_valid`=1; result fields are stable.
  - `res_valid & res_ready` → IDLE.
  - An `arm` in the accept cycle is ignored.
- **Counter rule:** with the start sample edge k and the stop sample edge k+n, coarse = n. Arithmetic is unsigned and never wraps.
- **Reset:** asynchronous; state IDLE; every output, flag and counter 0. A reset mid-measurement discards the measurement. A `*_fin` arriving after reset is ignored because it arrives in IDLE.

## Timing
- `*_go` is a registered pulse, exactly 1 cycle wide, 1 cycle after the sampling hit edge.
- Minimum hit-to-`res_valid` latency: stop sample edge + 1 (go) + 4 (decoder) + 1 (capture→OUT) = 6 cycles.
- `res_valid` holds until accepted. `busy` stays high during OUT.
- At most one measurement is in flight. There is no result buffering.

## Structure
- Shared package/defines (with `NUM_TAPS`, `NUM_DECODE`):
  - state encoding constants;
  - default `COARSE_W`;
  - default `DEC_TO`.
- One natural sub-module, `tdc_coarse_cnt`: saturating counter with clear/enable, latch output and overflow flag.
- The FSM, go pulse generation, capture registers and watchdog stay in the top module.

## Test plan
- **Nominal:** arm; start_hit at cycle 10; stop_hit at cycle 27; decoders return 0x05 and 0x11 four cycles after go → result coarse=17, fines 0x05/0x11, ovf=0, err=0, valid held until ready.
- **Simultaneous hits:** start_hit and stop_hit in the same cycle → both go pulses in the same cycle; coarse=0.
- **Overflow:** `COARSE_W`=4; no stop → coarse=15, ovf=1, stop_fine=0; stop_go never pulses.
- **Watchdog:** stop decoder never finishes → err=1 exactly `DEC_TO` cycles after stop_go; stop_fine=0; start fine is correct.
- **Ignored stimulus:**
  - stop_hit in ARMED and `arm` during RUN/OUT → no state change;
  - backpressure: ready low for 20 cycles → result fields stable.
- **Reset:** assert `rst` low mid-RUN and mid-OUT → all outputs 0 immediately, without waiting for a clock edge; a late `start_fin` after release → no `res_valid`.

Source files
------------

// File: rtl/tdc_measure_ctrl_pkg.sv
// Shared constants and state type for the TDC measurement sequencer.
package tdc_measure_ctrl_pkg;

    localparam int unsigned NUM_TAPS     = 32;
    // Fine code width produced by the start/stop edge-detector decoders
    localparam int unsigned NUM_DECODE   = 8;
    localparam int unsigned COARSE_W_DEF = 16;
    localparam int unsigned DEC_TO_DEF   = 7;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StArmed  = 3'd1,
        StRun    = 3'd2,
        StDecode = 3'd3,
        StOut    = 3'd4
    } state_e;

endpackage

// File: rtl/tdc_coarse_cnt.sv
// Saturating coarse cycle counter with a latched result and an overflow flag.
module tdc_coarse_cnt #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load_one,
    input  logic         en,
    input  logic         latch,
    output logic         at_max,
    output logic         ovf,
    output logic [W-1:0] lat
);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] lat_q, lat_d;
    logic         ovf_q, ovf_d;

    assign at_max = &cnt_q;
    assign ovf    = ovf_q;
    assign lat    = lat_q;

    always_comb begin
        cnt_d = cnt_q;
        lat_d = lat_q;
        ovf_d = ovf_q;
        if (clr) begin
            cnt_d = '0;
            lat_d = '0;
            ovf_d = 1'b0;
        end else begin
            if (load_one) begin
                cnt_d = {{(W-1){1'b0}}, 1'b1};
            end else if (en) begin
                // An increment request at all-ones flags overflow instead of wrapping
                if (at_max) begin
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            if (latch) begin
                lat_d = cnt_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            lat_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            lat_q <= lat_d;
            ovf_q <= ovf_d;
        end
    end

endmodule

// File: rtl/tdc_measure_ctrl.sv
// TDC channel measurement sequencer: arm, hit detection, coarse count, decoder
// handshake with watchdog, and a single-entry valid/ready result port.
module tdc_measure_ctrl
    import tdc_measure_ctrl_pkg::*;
#(
    parameter int unsigned COARSE_W = COARSE_W_DEF,
    parameter int unsigned DEC_TO   = DEC_TO_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arm,
    input  logic                  start_hit,
    input  logic                  stop_hit,
    output logic                  start_go,
    output logic                  stop_go,
    input  logic                  start_fin,
    input  logic                  stop_fin,
    input  logic [NUM_DECODE-1:0] start_fine,
    input  logic [NUM_DECODE-1:0] stop_fine,
    output logic                  busy,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [COARSE_W-1:0]   res_coarse,
    output logic [NUM_DECODE-1:0] res_start_fine,
    output logic [NUM_DECODE-1:0] res_stop_fine,
    output logic                  res_ovf,
    output logic                  res_err
);

    localparam int unsigned WD_W = $clog2(DEC_TO + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(DEC_TO - 1);

    state_e                  state_q, state_d;
    logic                    start_go_q, start_go_d;
    logic                    stop_go_q, stop_go_d;
    logic [NUM_DECODE-1:0]   sfine_q, sfine_d;
    logic [NUM_DECODE-1:0]   pfine_q, pfine_d;
    logic                    sdone_q, sdone_d;
    logic                    pdone_q, pdone_d;
    logic                    need_stop_q, need_stop_d;
    logic                    err_q, err_d;
    logic [WD_W-1:0]         wd_q, wd_d;

    logic                    capture;
    logic                    cnt_clr, cnt_load, cnt_en, cnt_latch;
    logic                    cnt_at_max;

    tdc_coarse_cnt #(
        .W (COARSE_W)
    ) u_coarse_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .load_one (cnt_load),
        .en       (cnt_en),
        .latch    (cnt_latch),
        .at_max   (cnt_at_max),
        .ovf      (res_ovf),
        .lat      (res_coarse)
    );

    always_comb begin
        state_d     = state_q;
        start_go_d  = 1'b0;
        stop_go_d   = 1'b0;
        sfine_d     = sfine_q;
        pfine_d     = pfine_q;
        sdone_d     = sdone_q;
        pdone_d     = pdone_q;
        need_stop_d = need_stop_q;
        err_d       = err_q;
        wd_d        = wd_q;
        capture     = 1'b0;
        cnt_clr     = 1'b0;
        cnt_load    = 1'b0;
        cnt_en      = 1'b0;
        cnt_latch   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (arm) begin
                    state_d     = StArmed;
                    cnt_clr     = 1'b1;
                    sfine_d     = '0;
                    pfine_d     = '0;
                    sdone_d     = 1'b0;
                    pdone_d     = 1'b0;
                    need_stop_d = 1'b0;
                    err_d       = 1'b0;
                end
            end
            StArmed: begin
                if (start_hit) begin
                    start_go_d = 1'b1;
                    wd_d       = '0;
                    if (stop_hit) begin
                        // Coarse latch still holds the zero written on arm
                        stop_go_d   = 1'b1;
                        need_stop_d = 1'b1;
                        state_d     = StDecode;
                    end else begin
                        cnt_load = 1'b1;
                        state_d  = StRun;
                    end
                end
            end
            StRun: begin
                capture = 1'b1;
                if (stop_hit) begin
                    cnt_latch   = 1'b1;
                    stop_go_d   = 1'b1;
                    need_stop_d = 1'b1;
                    wd_d        = '0;
                    state_d     = StDecode;
                end else begin
                    cnt_en = 1'b1;
                    if (cnt_at_max) begin
                        cnt_latch = 1'b1;
                        wd_d      = '0;
                        state_d   = StDecode;
                    end
                end
            end
            StDecode: begin
                if (sdone_q && (pdone_q || !need_stop_q)) begin
                    state_d = StOut;
                end else if (wd_q == WD_LAST) begin
                    // Missing fine codes stay at the zero written on arm
                    err_d   = 1'b1;
                    state_d = StOut;
                end else begin
                    capture = 1'b1;
                    wd_d    = wd_q + 1'b1;
                end
            end
            StOut: begin
                if (res_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (capture) begin
            if (start_fin && !sdone_q) begin
                sfine_d = start_fine;
                sdone_d = 1'b1;
            end
            if (stop_fin && need_stop_q && !pdone_q) begin
                pfine_d = stop_fine;
                pdone_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            start_go_q  <= 1'b0;
            stop_go_q   <= 1'b0;
            sfine_q     <= '0;
            pfine_q     <= '0;
            sdone_q     <= 1'b0;
            pdone_q     <= 1'b0;
            need_stop_q <= 1'b0;
            err_q       <= 1'b0;
            wd_q        <= '0;
        end else begin
            state_q     <= state_d;
            start_go_q  <= start_go_d;
            stop_go_q   <= stop_go_d;
            sfine_q     <= sfine_d;
            pfine_q     <= pfine_d;
            sdone_q     <= sdone_d;
            pdone_q     <= pdone_d;
            need_stop_q <= need_stop_d;
            err_q       <= err_d;
            wd_q        <= wd_d;
        end
    end

    assign start_go       = start_go_q;
    assign stop_go        = stop_go_q;
    assign busy           = (state_q != StIdle);
    assign res_valid      = (state_q == StOut);
    assign res_start_fine = sfine_q;
    assign res_stop_fine  = pfine_q;
    assign res_err        = err_q;

endmodule

// File: tb/tb_tdc_measure_ctrl.sv
// Self-checking bench for tdc_measure_ctrl: timestamp-based reference model,
// per-cycle compare, directed scenarios and randomized traffic.
module tb_tdc_measure_ctrl;
    import tdc_measure_ctrl_pkg::*;

    localparam int unsigned CW   = 16;
    localparam int unsigned DTO  = 7;
    localparam int unsigned FW   = NUM_DECODE;
    localparam int          CMAX = (1 << CW) - 1;

    localparam int P_IDLE = 0, P_ARMED = 1, P_RUN = 2, P_DEC = 3, P_OUT = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          arm = 1'b0, start_hit = 1'b0, stop_hit = 1'b0, res_ready = 1'b0;
    logic          start_fin = 1'b0, stop_fin = 1'b0;
    logic [FW-1:0] start_fine = '0, stop_fine = '0;
    logic          start_go, stop_go, busy, res_valid, res_ovf, res_err;
    logic [CW-1:0] res_coarse;
    logic [FW-1:0] res_start_fine, res_stop_fine;

    // Second instance with a narrow counter, used only for the overflow case
    logic          o_arm = 1'b0, o_start = 1'b0, o_ready = 1'b0, o_sfin = 1'b0;
    logic [FW-1:0] o_sfine = '0;
    logic          o_sgo, o_pgo, o_busy, o_valid, o_ovf, o_err;
    logic [3:0]    o_coarse;
    logic [FW-1:0] o_rs, o_rp;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    tdc_measure_ctrl #(.COARSE_W(CW), .DEC_TO(DTO)) dut (
        .clk(clk), .rst(rst), .arm(arm), .start_hit(start_hit), .stop_hit(stop_hit),
        .start_go(start_go), .stop_go(stop_go), .start_fin(start_fin), .stop_fin(stop_fin),
        .start_fine(start_fine), .stop_fine(stop_fine), .busy(busy), .res_valid(res_valid),
        .res_ready(res_ready), .res_coarse(res_coarse), .res_start_fine(res_start_fine),
        .res_stop_fine(res_stop_fine), .res_ovf(res_ovf), .res_err(res_err)
    );

    tdc_measure_ctrl #(.COARSE_W(4), .DEC_TO(DTO)) dut_ovf (
        .clk(clk), .rst(rst), .arm(o_arm), .start_hit(o_start), .stop_hit(1'b0),
        .start_go(o_sgo), .stop_go(o_pgo), .start_fin(o_sfin), .stop_fin(1'b0),
        .start_fine(o_sfine), .stop_fine(8'hff), .busy(o_busy), .res_valid(o_valid),
        .res_ready(o_ready), .res_coarse(o_coarse), .res_start_fine(o_rs),
        .res_stop_fine(o_rp), .res_ovf(o_ovf), .res_err(o_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (edge timestamps) ----------------
    int            ph = P_IDLE;
    int            cyc = 0, t_start = 0, t_dec = 0;
    bit            e_sgo = 0, e_pgo = 0, e_ovf = 0, e_err = 0;
    bit            s_done = 0, p_done = 0, need_p = 0;
    int            e_coarse = 0;
    logic [FW-1:0] e_sfine = '0, e_pfine = '0;

    task automatic take_fins();
        if (start_fin && !s_done) begin e_sfine = start_fine; s_done = 1; end
        if (stop_fin && need_p && !p_done) begin e_pfine = stop_fine; p_done = 1; end
    endtask

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) begin
            ph = P_IDLE; e_sgo = 0; e_pgo = 0; e_ovf = 0; e_err = 0; e_coarse = 0;
            e_sfine = '0; e_pfine = '0; s_done = 0; p_done = 0; need_p = 0;
        end else begin
            cyc++;
            e_sgo = 0;
            e_pgo = 0;
            case (ph)
                P_IDLE: if (arm) begin
                    ph = P_ARMED; e_sfine = '0; e_pfine = '0; e_coarse = 0; e_ovf = 0;
                    e_err = 0; s_done = 0; p_done = 0; need_p = 0;
                end
                P_ARMED: if (start_hit && stop_hit) begin
                    e_sgo = 1; e_pgo = 1; e_coarse = 0; need_p = 1; t_dec = cyc; ph = P_DEC;
                end else if (start_hit) begin
                    e_sgo = 1; t_start = cyc; ph = P_RUN;
                end
                P_RUN: begin
                    take_fins();
                    if (stop_hit) begin
                        e_coarse = cyc - t_start; e_pgo = 1; need_p = 1; t_dec = cyc; ph = P_DEC;
                    end else if (cyc - t_start == CMAX) begin
                        e_coarse = CMAX; e_ovf = 1; t_dec = cyc; ph = P_DEC;
                    end
                end
                P_DEC: begin
                    if (s_done && (p_done || !need_p)) ph = P_OUT;
                    else if (cyc - t_dec == int'(DTO)) begin e_err = 1; ph = P_OUT; end
                    else take_fins();
                end
                P_OUT: if (res_ready) ph = P_IDLE;
                default: ph = P_IDLE;
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        if (rst) begin
            chk("busy", busy, ph != P_IDLE);
            chk("res_valid", res_valid, ph == P_OUT);
            chk("start_go", start_go, e_sgo);
            chk("stop_go", stop_go, e_pgo);
            if (ph == P_OUT) begin
                chk("res_coarse", res_coarse, e_coarse);
                chk("res_start_fine", res_start_fine, e_sfine);
                chk("res_stop_fine", res_stop_fine, e_pfine);
                chk("res_ovf", res_ovf, e_ovf);
                chk("res_err", res_err, e_err);
            end
        end
    end

    // ---------------- decoder responders ----------------
    bit            rand_dec = 0, s_en = 1, p_en = 1;
    int            s_cd = 0, p_cd = 0;
    logic [FW-1:0] s_val = 8'h05, p_val = 8'h11;

    initial forever begin
        @(negedge clk);
        start_fin = 1'b0;
        stop_fin = 1'b0;
        start_fine = FW'($urandom);
        stop_fine = FW'($urandom);
        if (s_cd > 0) begin s_cd--; if (s_cd == 0) begin start_fin = 1'b1; start_fine = s_val; end end
        if (p_cd > 0) begin p_cd--; if (p_cd == 0) begin stop_fin = 1'b1; stop_fine = p_val; end end
        if (start_go && s_en) begin
            if (rand_dec) begin
                s_val = FW'($urandom);
                s_cd = ($urandom % 10 == 0) ? 0 : 2 + int'($urandom % 4);
            end else s_cd = 4;
        end
        if (stop_go && p_en) begin
            if (rand_dec) begin
                p_val = FW'($urandom);
                p_cd = ($urandom % 10 == 0) ? 0 : 2 + int'($urandom % 4);
            end else p_cd = 4;
        end
    end

    int o_pgo_seen = 0;
    initial forever begin
        @(negedge clk);
        if (o_pgo) o_pgo_seen++;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench time limit");
    end

    // ---------------- helpers ----------------
    task automatic wait_valid(input string tag, input int budget, output int n);
        n = 0;
        while (!res_valid && n < budget) begin @(negedge clk); n++; end
        if (!res_valid) chk(tag, 0, 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_valid"}, res_valid, 0);
        chk({tag, "_gos"}, {start_go, stop_go}, 0);
        chk({tag, "_coarse"}, res_coarse, 0);
        chk({tag, "_fines"}, {res_start_fine, res_stop_fine}, 0);
        chk({tag, "_flags"}, {res_ovf, res_err}, 0);
    endtask

    task automatic pulse_arm();
        arm = 1'b1; @(negedge clk); arm = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        #3 rst = 1'b0;
        #1 chk_all_zero(tag);
        @(negedge clk);
        #2 rst = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    int n;
    initial begin
        #2 rst = 1'b0;
        #1 chk_all_zero("reset");
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);

        // Nominal: coarse 17, fines 0x05/0x11, latency 6 from stop sample
        pulse_arm();
        @(negedge clk);
        start_hit = 1'b1; @(negedge clk); start_hit = 1'b0;
        chk("nom_start_go", start_go, 1);
        for (int i = 0; i < 16; i++) begin arm = (i == 5); @(negedge clk); end
        arm = 1'b0;
        stop_hit = 1'b1; @(negedge clk); stop_hit = 1'b0;
        chk("nom_stop_go", stop_go, 1);
        wait_valid("nom_valid_timeout", 30, n);
        chk("nom_latency", n, 6);
        for (int i = 0; i < 20; i++) begin arm = (i == 3); @(negedge clk); end
        arm = 1'b0;
        chk("nom_hold_valid", res_valid, 1);
        chk("nom_coarse", res_coarse, 17);
        chk("nom_sfine", res_start_fine, 8'h05);
        chk("nom_pfine", res_stop_fine, 8'h11);
        chk("nom_flags", {res_ovf, res_err}, 0);
        res_ready = 1'b1; arm = 1'b1; @(negedge clk); res_ready = 1'b0; arm = 1'b0;
        chk("accept_arm_ignored", busy, 0);

        // Stop alone in ARMED ignored, then simultaneous hits
        pulse_arm();
        stop_hit = 1'b1; @(negedge clk); stop_hit = 1'b0;
        chk("armed_stop_ignored", {busy, stop_go}, 2'b10);
        start_hit = 1'b1; stop_hit = 1'b1; @(negedge clk); start_hit = 1'b0; stop_hit = 1'b0;
        chk("sim_both_go", {start_go, stop_go}, 2'b11);
        wait_valid("sim_valid_timeout", 30, n);
        chk("sim_coarse", res_coarse, 0);
        res_ready = 1'b1; @(negedge clk); res_ready = 1'b0;

        // Watchdog: stop decoder silent
        p_en = 0; s_val = 8'h3c;
        pulse_arm();
        start_hit = 1'b1; @(negedge clk); start_hit = 1'b0;
        repeat (5) @(negedge clk);
        stop_hit = 1'b1; @(negedge clk); stop_hit = 1'b0;
        wait_valid("wd_valid_timeout", 30, n);
        chk("wd_delay", n, DTO);
        chk("wd_err", res_err, 1);
        chk("wd_pfine", res_stop_fine, 0);
        chk("wd_sfine", res_start_fine, 8'h3c);
        res_ready = 1'b1; @(negedge clk); res_ready = 1'b0;
        p_en = 1;

        // Reset mid-RUN; the pending start_fin lands after release
        pulse_arm();
        start_hit = 1'b1; @(negedge clk); start_hit = 1'b0;
        repeat (2) @(negedge clk);
        do_reset("rst_run");
        repeat (8) @(negedge clk);
        chk("late_fin_no_valid", {busy, res_valid}, 0);

        // Reset mid-OUT
        pulse_arm();
        start_hit = 1'b1; @(negedge clk); start_hit = 1'b0;
        repeat (3) @(negedge clk);
        stop_hit = 1'b1; @(negedge clk); stop_hit = 1'b0;
        wait_valid("rst_out_valid_timeout", 30, n);
        do_reset("rst_out");
        @(negedge clk);

        // Randomized traffic
        rand_dec = 1;
        repeat (3000) begin
            arm = ($urandom % 8) == 0;
            start_hit = ($urandom % 5) == 0;
            stop_hit = ($urandom % 9) == 0;
            res_ready = ($urandom % 3) != 0;
            @(negedge clk);
        end
        arm = 1'b0; start_hit = 1'b0; stop_hit = 1'b0; res_ready = 1'b1;
        repeat (20) @(negedge clk);

        // Overflow on the 4-bit instance: no stop ever
        o_arm = 1'b1; @(negedge clk); o_arm = 1'b0;
        o_start = 1'b1; @(negedge clk); o_start = 1'b0;
        chk("ovf_start_go", o_sgo, 1);
        n = 0;
        repeat (4) begin @(negedge clk); n++; end
        o_sfin = 1'b1; o_sfine = 8'h2a; @(negedge clk); o_sfin = 1'b0; o_sfine = '0; n++;
        while (!o_valid && n < 60) begin @(negedge clk); n++; end
        chk("ovf_latency", n, 16);
        chk("ovf_coarse", o_coarse, 15);
        chk("ovf_flag", o_ovf, 1);
        chk("ovf_err", o_err, 0);
        chk("ovf_pfine", o_rp, 0);
        chk("ovf_sfine", o_rs, 8'h2a);
        chk("ovf_no_stop_go", o_pgo_seen, 0);
        o_ready = 1'b1; @(negedge clk); o_ready = 1'b0;
        chk("ovf_accept", o_busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
